mult_run_ctrl: RTL and testbench

Hardware run controller placed directly upstream of TopLevel. It feeds two signed 16-bit operands into data memory bytes 1..4 (MSB first) and drives TopLevel's start. It then counts cycles until halt, reads the 32-bit product back from bytes 5..8, and presents it with a done pulse. It replaces bench-side preload and polling so the multiply program can run on hardware and in batch regressions.

---
 rtl/mult_run_pkg.sv | 19 +
 rtl/mem_byte_seq.sv | 28 ++
 rtl/mult_run_ctrl.sv | 149 ++++++++++++++
 tb/tb_mult_run_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_run_pkg.sv
// Shared types and memory map for the multiply run controller.
// Operands sit at bytes 1..4, the product at bytes 5..8.
package mult_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    RUN,
    READ,
    FIN
  } state_t;

  localparam int OPA_ADDR  = 1;
  localparam int OPB_ADDR  = 3;
  localparam int PROD_ADDR = 5;
  localparam int NBYTES    = 4;

endpackage

// File: rtl/mem_byte_seq.sv
// Four-byte index/address sequencer shared by operand load and readback.
// The index wraps after the last byte, so every burst starts at zero.
module mem_byte_seq
  import mult_run_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  output logic [1:0]        idx,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  assign last = (idx == 2'(NBYTES - 1));
  assign addr = base + ADDR_W'(idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
    end else if (en) begin
      idx <= last ? 2'd0 : idx + 2'd1;
    end
  end

endmodule

// File: rtl/mult_run_ctrl.sv
// Run controller for TopLevel: loads operands, launches the program,
// times it until halt and reads the 32-bit product back.
module mult_run_ctrl
  import mult_run_pkg::*;
#(
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 65535,
  parameter int ADDR_W    = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              go,
  input  logic [15:0]       op_a,
  input  logic [15:0]       op_b,
  input  logic              halt,
  output logic              start,
  output logic              mem_own,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       product,
  output logic [31:0]       cycle_ct
);

  state_t state, nxt;

  logic [31:0]       ops;
  logic [31:0]       launch_ct;
  logic [31:0]       ct_inc;
  logic              seq_en;
  logic [ADDR_W-1:0] seq_base;
  logic [ADDR_W-1:0] seq_addr;
  logic [1:0]        idx;
  logic              last;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [7:0]        wr_byte;

  mem_byte_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk (CLK),
    .rst (reset),
    .en  (seq_en),
    .base(seq_base),
    .idx (idx),
    .addr(seq_addr),
    .last(last)
  );

  assign ct_inc = cycle_ct + 32'd1;
  assign busy   = (state != IDLE);
  assign done   = (state == FIN);

  always_comb begin
    wr_byte = 8'h00;
    if (seq_addr < ADDR_W'(OPB_ADDR)) begin
      wr_byte = idx[0] ? ops[23:16] : ops[31:24];
    end else begin
      wr_byte = idx[0] ? ops[7:0] : ops[15:8];
    end
  end

  // Address and data hold their last driven value while not owned.
  assign mem_addr    = mem_own ? seq_addr : addr_q;
  assign mem_wr_data = mem_wr_en ? wr_byte : data_q;

  always_comb begin
    nxt       = state;
    seq_en    = 1'b0;
    mem_own   = 1'b0;
    mem_wr_en = 1'b0;
    seq_base  = ADDR_W'(OPA_ADDR);
    unique case (state)
      IDLE: begin
        if (go) nxt = LOAD;
      end
      LOAD: begin
        mem_own   = 1'b1;
        mem_wr_en = 1'b1;
        seq_en    = 1'b1;
        if (last) nxt = LAUNCH;
      end
      LAUNCH: begin
        if (launch_ct >= 32'(START_CYC - 1)) nxt = RUN;
      end
      RUN: begin
        if (halt) nxt = READ;
        else if (ct_inc >= 32'(TIMEOUT)) nxt = FIN;
      end
      READ: begin
        mem_own  = 1'b1;
        seq_en   = 1'b1;
        seq_base = ADDR_W'(PROD_ADDR);
        if (last) nxt = FIN;
      end
      FIN: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      start     <= 1'b1;
      ops       <= 32'd0;
      launch_ct <= 32'd0;
      product   <= 32'd0;
      cycle_ct  <= 32'd0;
      err       <= 1'b0;
      addr_q    <= '0;
      data_q    <= 8'h00;
    end else begin
      // TopLevel runs through RUN and the readback, re-inits at FIN.
      start <= !(nxt == RUN || nxt == READ);
      if (mem_own)   addr_q <= seq_addr;
      if (mem_wr_en) data_q <= wr_byte;
      launch_ct <= (state == LAUNCH) ? launch_ct + 32'd1 : 32'd0;
      if (state == IDLE && go) begin
        ops      <= {op_a, op_b};
        product  <= 32'd0;
        cycle_ct <= 32'd0;
        err      <= 1'b0;
      end
      if (state == RUN && !halt) begin
        if (ct_inc >= 32'(TIMEOUT)) begin
          cycle_ct <= 32'(TIMEOUT);
          err      <= 1'b1;
        end else begin
          cycle_ct <= ct_inc;
        end
      end
      if (state == READ) product <= {product[23:0], mem_rd_data};
    end
  end

endmodule

// File: tb/tb_mult_run_ctrl.sv
// Bench for mult_run_ctrl with a behavioural memory and TopLevel model
// that multiplies the operands it finds in memory and raises halt.
module tb_mult_run_ctrl;

  localparam int SC = 2;
  localparam int TO = 20;

  logic        CLK = 1'b0;
  logic        reset;
  logic        go;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        halt = 1'b0;
  logic        start;
  logic        mem_own;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] product;
  logic [31:0] cycle_ct;

  mult_run_ctrl #(
    .START_CYC(SC),
    .TIMEOUT  (TO),
    .ADDR_W   (8)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .go         (go),
    .op_a       (op_a),
    .op_b       (op_b),
    .halt       (halt),
    .start      (start),
    .mem_own    (mem_own),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .product    (product),
    .cycle_ct   (cycle_ct)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  mem [256];
  logic [15:0] wlog [$];
  logic [7:0]  rlog [$];
  int          hold_at = -1;
  int          run_n = 0;
  int          tests = 0;
  int          fails = 0;

  assign mem_rd_data = mem[mem_addr];

  always @(negedge CLK) begin
    if (mem_own && mem_wr_en) begin
      mem[mem_addr] = mem_wr_data;
      wlog.push_back({mem_addr, mem_wr_data});
    end
    if (mem_own && !mem_wr_en) rlog.push_back(mem_addr);
  end

  // TopLevel stand-in: runs while start is low, halts after hold_at cycles.
  always @(negedge CLK) begin
    logic signed [31:0] p;
    if (start) begin
      run_n = 0;
      halt  = 1'b0;
    end else begin
      run_n++;
      if (hold_at >= 0 && run_n > hold_at && !halt) begin
        p = $signed({mem[1], mem[2]}) * $signed({mem[3], mem[4]});
        mem[5] = p[31:24];
        mem[6] = p[23:16];
        mem[7] = p[15:8];
        mem[8] = p[7:0];
        halt = 1'b1;
      end
    end
  end

  task automatic run_one(input string nm, input logic [15:0] a,
                         input logic [15:0] b, input int hd,
                         input bit go_mid);
    int          lat;
    int          dn;
    bit          seen;
    logic [31:0] pexp;
    logic [31:0] ctexp;
    logic [7:0]  eb [4];
    eb[0] = a[15:8];
    eb[1] = a[7:0];
    eb[2] = b[15:8];
    eb[3] = b[7:0];
    ctexp = (hd < 0) ? 32'(TO) : 32'(hd);
    pexp  = (hd < 0) ? 32'd0 : 32'(int'($signed(a)) * int'($signed(b)));
    hold_at = hd;
    wlog.delete();
    rlog.delete();
    @(negedge CLK);
    op_a = a;
    op_b = b;
    go   = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge CLK);
      go   = 1'b0;
      op_a = a;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (go_mid && i == 10) begin
        go   = 1'b1;
        op_a = ~a;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s done_timeout got none want pulse", nm);
      return;
    end
    tests++;
    if (product !== pexp) begin
      fails++;
      $display("FAIL %s product got %h want %h", nm, product, pexp);
    end
    tests++;
    if (cycle_ct !== ctexp) begin
      fails++;
      $display("FAIL %s cycle_ct got %0d want %0d", nm, cycle_ct, ctexp);
    end
    tests++;
    if (err !== (hd < 0)) begin
      fails++;
      $display("FAIL %s err got %b want %b", nm, err, hd < 0);
    end
    if (hd >= 0) begin
      tests++;
      if (lat != 4 + SC + hd + 1 + 4 + 1) begin
        fails++;
        $display("FAIL %s latency got %0d want %0d", nm, lat,
                 4 + SC + hd + 1 + 4 + 1);
      end
    end
    tests++;
    if (wlog.size() != 4) begin
      fails++;
      $display("FAIL %s nwrites got %0d want 4", nm, wlog.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        tests++;
        if (wlog[j] !== {8'(j + 1), eb[j]}) begin
          fails++;
          $display("FAIL %s write%0d got %h want %h", nm, j, wlog[j],
                   {8'(j + 1), eb[j]});
        end
      end
    end
    tests++;
    if (rlog.size() != ((hd < 0) ? 0 : 4)) begin
      fails++;
      $display("FAIL %s nreads got %0d want %0d", nm, rlog.size(),
               (hd < 0) ? 0 : 4);
    end else begin
      for (int j = 0; j < rlog.size(); j++) begin
        tests++;
        if (rlog[j] !== 8'(j + 5)) begin
          fails++;
          $display("FAIL %s read%0d got %0d want %0d", nm, j, rlog[j], j + 5);
        end
      end
    end
    dn = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      if (done) dn++;
    end
    tests++;
    if (dn != 0 || busy !== 1'b0 || start !== 1'b1) begin
      fails++;
      $display("FAIL %s after extra_done %0d busy %b start %b want 0 0 1",
               nm, dn, busy, start);
    end
    tests++;
    if (product !== pexp || cycle_ct !== ctexp) begin
      fails++;
      $display("FAIL %s hold got %h/%0d want %h/%0d", nm, product, cycle_ct,
               pexp, ctexp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go    = 1'b0;
    op_a  = 16'h0;
    op_b  = 16'h0;
    #12;
    tests++;
    if ({start, mem_own, mem_wr_en, busy, done, err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset ctl got %b want 100000",
               {start, mem_own, mem_wr_en, busy, done, err});
    end
    tests++;
    if (mem_addr !== 8'h0 || mem_wr_data !== 8'h0) begin
      fails++;
      $display("FAIL reset mem got %h/%h want 00/00", mem_addr, mem_wr_data);
    end
    tests++;
    if (product !== 32'h0 || cycle_ct !== 32'h0) begin
      fails++;
      $display("FAIL reset regs got %h/%h want 0/0", product, cycle_ct);
    end
    @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_one("basic", 16'h0003, 16'h0005, 10, 1'b0);
  endtask

  task automatic test_signed();
    run_one("signed", 16'hFFFF, 16'h7FFF, 4, 1'b0);
  endtask

  task automatic test_halt_entry();
    run_one("halt_entry", 16'h1234, 16'hFF00, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_one("timeout", 16'h0102, 16'h0304, -1, 1'b0);
  endtask

  task automatic test_go_busy();
    run_one("go_busy", 16'h8000, 16'h8000, 12, 1'b1);
  endtask

  task automatic test_async_reset();
    wlog.delete();
    hold_at = 5;
    @(negedge CLK);
    op_a = 16'hAAAA;
    op_b = 16'h5555;
    go   = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (start !== 1'b1 || mem_own !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got start %b own %b busy %b want 1 0 0",
               start, mem_own, busy);
    end
    @(negedge CLK);
    reset = 1'b0;
    run_one("after_reset", 16'h00FE, 16'hFFF3, 7, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    for (int n = 0; n < 6; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      run_one("random", a, b, int'($urandom_range(0, 15)), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_signed();
    test_halt_entry();
    test_timeout();
    test_go_busy();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
